// File: rtl/keyboard_ctrl.sv
// PS/2 scan-code parser for game controls: held keys, jump charge, events.
// Decodes E0/F0 prefixes, tracks key levels and times the space-bar charge.
module keyboard_ctrl #(
    parameter int CHARGE_DIV  = 1_000_000,
    parameter int CHARGE_MAX  = 63,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    output logic       key_left,
    output logic       key_right,
    output logic       key_space,
    output logic       key_esc,
    output logic       jump_press,
    output logic       jump_release,
    output logic       esc_press,
    output logic [5:0] jump_charge,
    output logic [5:0] jump_power
);

    localparam int PW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CHARGE_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [5:0]    CMAX     = 6'(CHARGE_MAX);

    // held-bit indices
    localparam int L_ARW = 0;
    localparam int K_A   = 1;
    localparam int R_ARW = 2;
    localparam int K_D   = 3;
    localparam int K_SP  = 4;
    localparam int K_ESC = 5;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q;
    logic [PW-1:0] presc_q;
    logic [5:0]    held_q, held_d, hit;
    logic [5:0]    charge_q, power_q;
    logic          jp_q, jr_q, ep_q;
    logic          jp_d, jr_d, ep_d;
    logic          is_e0, is_f0, ext, brk, key_ev, mk, bk;
    logic          timeout, wrap;

    assign is_e0   = code_byte == 8'hE0;
    assign is_f0   = code_byte == 8'hF0;
    assign timeout = (state_q != IDLE) && (tcnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (code_valid) begin
            unique case (state_q)
                IDLE:    state_d = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                EXT:     state_d = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
                BRK:     state_d = is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
                EXT_BRK: state_d = (is_e0 || is_f0) ? EXT_BRK : IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ext    = (state_q == EXT) || (state_q == EXT_BRK);
        brk    = (state_q == BRK) || (state_q == EXT_BRK);
        key_ev = code_valid && !is_e0 && !is_f0;
        mk     = key_ev && !brk;
        bk     = key_ev && brk;
        hit        = '0;
        hit[L_ARW] = ext  && (code_byte == 8'h6B);
        hit[K_A]   = !ext && (code_byte == 8'h1C);
        hit[R_ARW] = ext  && (code_byte == 8'h74);
        hit[K_D]   = !ext && (code_byte == 8'h23);
        hit[K_SP]  = !ext && (code_byte == 8'h29);
        hit[K_ESC] = !ext && (code_byte == 8'h76);
        held_d = held_q;
        if (mk) held_d = held_q | hit;
        if (bk) held_d = held_q & ~hit;
        jp_d = mk && hit[K_SP] && !held_q[K_SP];
        jr_d = bk && hit[K_SP] && held_q[K_SP];
        ep_d = mk && hit[K_ESC] && !held_q[K_ESC];
    end

    assign wrap = held_q[K_SP] && (presc_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q   <= '0;
            jp_q     <= 1'b0;
            jr_q     <= 1'b0;
            ep_q     <= 1'b0;
            charge_q <= '0;
            power_q  <= '0;
            presc_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            held_q <= held_d;
            jp_q   <= jp_d;
            jr_q   <= jr_d;
            ep_q   <= ep_d;
            if (code_valid || state_q == IDLE || tcnt_q == TO_LAST)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + 1'b1;
            // power takes the pre-increment charge if a wrap coincides
            if (jp_d) begin
                charge_q <= '0;
                presc_q  <= '0;
            end else if (jr_d) begin
                power_q  <= charge_q;
                charge_q <= '0;
                presc_q  <= '0;
            end else if (held_q[K_SP]) begin
                presc_q <= wrap ? '0 : presc_q + 1'b1;
                if (wrap && charge_q < CMAX)
                    charge_q <= charge_q + 1'b1;
            end
        end
    end

    assign key_left     = held_q[L_ARW] | held_q[K_A];
    assign key_right    = held_q[R_ARW] | held_q[K_D];
    assign key_space    = held_q[K_SP];
    assign key_esc      = held_q[K_ESC];
    assign jump_press   = jp_q;
    assign jump_release = jr_q;
    assign esc_press    = ep_q;
    assign jump_charge  = charge_q;
    assign jump_power   = power_q;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Bench for keyboard_ctrl: key-map table, directed charge/timeout/reset
// sequences and random byte streams against a reference model.
module tb_keyboard_ctrl;

    localparam int DIV = 4;
    localparam int MAX = 63;
    localparam int TO  = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code_byte;
    logic       key_left, key_right, key_space, key_esc;
    logic       jump_press, jump_release, esc_press;
    logic [5:0] jump_charge, jump_power;

    keyboard_ctrl #(
        .CHARGE_DIV (DIV),
        .CHARGE_MAX (MAX),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_valid  (code_valid),
        .code_byte   (code_byte),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_space   (key_space),
        .key_esc     (key_esc),
        .jump_press  (jump_press),
        .jump_release(jump_release),
        .esc_press   (esc_press),
        .jump_charge (jump_charge),
        .jump_power  (jump_power)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int       cyc, last_v, make_cyc, m_power;
    bit       m_ext, m_brk;
    bit [5:0] m_held;
    bit       e_jp, e_jr, e_ep;

    typedef struct {
        bit         v;
        logic [7:0] b;
        logic [3:0] keys;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    function automatic int src_of(input bit e, input logic [7:0] b);
        if (e && b == 8'h6B) return 0;
        if (!e && b == 8'h1C) return 1;
        if (e && b == 8'h74) return 2;
        if (!e && b == 8'h23) return 3;
        if (!e && b == 8'h29) return 4;
        if (!e && b == 8'h76) return 5;
        return -1;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = '0; m_power = 0;
        e_jp = 0; e_jr = 0; e_ep = 0;
        last_v = cyc; make_cyc = cyc;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] b);
        int s;
        e_jp = 0; e_jr = 0; e_ep = 0;
        if (!v) return;
        if ((m_ext || m_brk) && (cyc - last_v - 1) >= TO) begin
            m_ext = 0; m_brk = 0;
        end
        last_v = cyc;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            s = src_of(m_ext, b);
            if (s >= 0 && !m_brk && !m_held[s]) begin
                m_held[s] = 1;
                if (s == 4) begin e_jp = 1; make_cyc = cyc; end
                if (s == 5) e_ep = 1;
            end else if (s >= 0 && m_brk && m_held[s]) begin
                m_held[s] = 0;
                if (s == 4) begin
                    e_jr = 1;
                    m_power = min_i(MAX, (cyc - make_cyc - 1) / DIV);
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        logic [18:0] got, exp;
        int ch;
        @(negedge clk);
        code_valid = v;
        code_byte  = b;
        @(posedge clk);
        cyc++;
        model_edge(v, b);
        #1;
        code_valid = 1'b0;
        ch  = m_held[4] ? min_i(MAX, (cyc - make_cyc) / DIV) : 0;
        got = {key_left, key_right, key_space, key_esc, jump_press,
               jump_release, esc_press, jump_charge, jump_power};
        exp = {m_held[0] | m_held[1], m_held[2] | m_held[3], m_held[4],
               m_held[5], e_jp, e_jr, e_ep, 6'(ch), 6'(m_power)};
        check("model", 32'(got), 32'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00);
    endtask

    task automatic do_reset();
        logic [18:0] got;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {key_left, key_right, key_space, key_esc, jump_press,
               jump_release, esc_press, jump_charge, jump_power};
        check("reset_zero", 32'(got), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];
    logic [7:0] pick [12] = '{8'hE0, 8'hF0, 8'h6B, 8'h1C, 8'h74, 8'h23,
                              8'h29, 8'h76, 8'hE0, 8'hF0, 8'h29, 8'h29};

    initial begin
        int npress;
        cyc = 0;
        rst_n = 1'b0;
        code_valid = 1'b0;
        code_byte = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // key map and prefix handling
        tbl.push_back('{1, 8'hE0, 4'b0000});
        tbl.push_back('{1, 8'h6B, 4'b1000});
        tbl.push_back('{1, 8'h1C, 4'b1000});
        tbl.push_back('{1, 8'hE0, 4'b1000});
        tbl.push_back('{1, 8'hF0, 4'b1000});
        tbl.push_back('{1, 8'h6B, 4'b1000});
        tbl.push_back('{1, 8'hF0, 4'b1000});
        tbl.push_back('{1, 8'h1C, 4'b0000});
        tbl.push_back('{1, 8'h74, 4'b0000});
        tbl.push_back('{1, 8'h23, 4'b0100});
        tbl.push_back('{1, 8'hE0, 4'b0100});
        tbl.push_back('{1, 8'h74, 4'b0100});
        tbl.push_back('{1, 8'hF0, 4'b0100});
        tbl.push_back('{1, 8'h23, 4'b0100});
        tbl.push_back('{1, 8'hE0, 4'b0100});
        tbl.push_back('{1, 8'hF0, 4'b0100});
        tbl.push_back('{1, 8'h74, 4'b0000});
        tbl.push_back('{1, 8'h76, 4'b0001});
        tbl.push_back('{1, 8'h76, 4'b0001});
        tbl.push_back('{1, 8'hF0, 4'b0001});
        tbl.push_back('{1, 8'h76, 4'b0000});
        tbl.push_back('{1, 8'hE0, 4'b0000});
        tbl.push_back('{1, 8'h29, 4'b0000});
        tbl.push_back('{1, 8'hE0, 4'b0000});
        tbl.push_back('{1, 8'hE0, 4'b0000});
        tbl.push_back('{1, 8'h6B, 4'b1000});
        tbl.push_back('{1, 8'hF0, 4'b1000});
        tbl.push_back('{1, 8'hF0, 4'b1000});
        tbl.push_back('{1, 8'hE0, 4'b1000});
        tbl.push_back('{1, 8'hF0, 4'b1000});
        tbl.push_back('{1, 8'h6B, 4'b0000});
        tbl.push_back('{0, 8'h29, 4'b0000});
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].b);
            check("keymap", 32'({key_left, key_right, key_space, key_esc}),
                  32'(tbl[i].keys));
        end

        // charge over three steps
        step(1, 8'h29);
        check("jump_press", 32'(jump_press), 32'd1);
        idle(3 * DIV);
        step(1, 8'hF0);
        step(1, 8'h29);
        check("jump_release", 32'(jump_release), 32'd1);
        check("power3", 32'(jump_power), 32'd3);
        check("charge_clr", 32'(jump_charge), 32'd0);
        step(0, 8'h00);
        check("release_pulse", 32'(jump_release), 32'd0);

        // saturation
        step(1, 8'h29);
        idle(100 * DIV);
        check("charge_sat", 32'(jump_charge), 32'(MAX));
        step(1, 8'hF0);
        step(1, 8'h29);
        check("power_sat", 32'(jump_power), 32'(MAX));

        // prefix timeout and coincident byte
        step(1, 8'hE0);
        idle(TO);
        step(1, 8'h74);
        check("timeout_drop", 32'(key_right), 32'd0);
        step(1, 8'hE0);
        idle(TO - 1);
        step(1, 8'h74);
        check("timeout_edge", 32'(key_right), 32'd1);
        step(1, 8'hE0);
        step(1, 8'hF0);
        step(1, 8'h74);

        // typematic repeat
        npress = 0;
        step(1, 8'h29);
        npress += int'(jump_press);
        for (int r = 0; r < 4; r++) begin
            idle(3);
            step(1, 8'h29);
            npress += int'(jump_press);
        end
        check("repeat_press", 32'(npress), 32'd1);
        check("repeat_charge", 32'(jump_charge), 32'd4);
        step(1, 8'hF0);
        step(1, 8'h29);

        // reset mid-charge
        step(1, 8'h29);
        idle(5 * DIV);
        check("charge5", 32'(jump_charge), 32'd5);
        do_reset();
        step(1, 8'hF0);
        step(1, 8'h29);
        check("no_release", 32'(jump_release), 32'd0);

        // random streams
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) idle(int'($urandom_range(15, 30)));
            else if (r < 4 && i % 500 == 7) do_reset();
            else if (r < 40) begin
                if ($urandom_range(0, 9) == 0) step(1, 8'($urandom));
                else step(1, pick[$urandom_range(0, 11)]);
            end else step(0, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keyboard_ctrl.md
KEYBOARD_CTRL -- requirements
Module: keyboard_ctrl

Interface
REQ-001 SHALL have parameter CHARGE_DIV, default 1_000_000, meaning clk cycles per jump-charge step (10 ms at 100 MHz).
REQ-002 SHALL have parameter CHARGE_MAX, default 63, meaning jump-charge saturation value (≤63).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_000_000, meaning idle cycles before a pending prefix is discarded.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge; single clock domain.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port code_valid  input  1  one-cycle strobe, new scan byte available (receiver oflag).
REQ-007 SHALL have port code_byte  input  8  newest scan byte (receiver keycode[7:0]); sampled only when code_valid=1.
REQ-008 SHALL have ports key_left, key_right, key_space, key_esc  output  1 each  held-key levels.
REQ-009 SHALL have ports jump_press, jump_release, esc_press  output  1 each  one-cycle event pulses.
REQ-010 SHALL have port jump_charge  output  6  live charge while space held.
REQ-011 SHALL have port jump_power  output  6  charge latched at release; valid from the jump_release cycle until the next release.

Function
REQ-012 SHALL run a parser FSM with states IDLE, EXT, BRK, EXT_BRK; transitions occur only on code_valid=1.
REQ-013 IDLE: E0->EXT; F0->BRK; other byte -> make(byte, ext=0), stay IDLE.
REQ-014 EXT: F0->EXT_BRK; E0 stays EXT; other -> make(byte, ext=1), ->IDLE.
REQ-015 BRK: F0 stays BRK; E0->EXT_BRK; other -> break(byte, ext=0), ->IDLE.
REQ-016 EXT_BRK: E0/F0 stay; other -> break(byte, ext=1), ->IDLE.
REQ-017 Key map: left = {ext,6B} or {noext,1C}; right = {ext,74} or {noext,23}; space = {noext,29}; esc = {noext,76}; all other codes ignored with no output change.
REQ-018 SHALL keep one held bit per source (left-arrow, A, right-arrow, D, space, esc); key_left = left-arrow|A, key_right = right-arrow|D.
REQ-019 Make sets and break clears the source bit; outputs reflect it on the cycle after code_valid (latency 1).
REQ-020 Make of an already-held key (typematic repeat) SHALL produce no pulse and no charge reset; break of a non-held key SHALL be ignored.
REQ-021 Space make while not held: jump_press=1 for one cycle, jump_charge<=0, prescaler<=0.
REQ-022 While key_space=1: prescaler counts 0..CHARGE_DIV-1 and wraps; on wrap jump_charge increments, saturating at CHARGE_MAX.
REQ-023 Space break while held: jump_release=1 for one cycle, jump_power<=jump_charge pre-increment value when a wrap coincides, jump_charge<=0.
REQ-024 Esc make while not held: esc_press=1 for one cycle.
REQ-025 Timeout counter SHALL clear on every code_valid; in a non-IDLE state, reaching TIMEOUT_CYC-1 returns FSM to IDLE with the partial sequence discarded and no output change.
REQ-026 code_valid coinciding with the timeout terminal count: the byte SHALL be processed and the timeout ignored.
REQ-027 jump_charge SHALL be 0 whenever key_space=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force FSM=IDLE, all held bits, pulses, jump_charge, jump_power, prescaler, and timeout counter to 0.
REQ-029 Reset mid-sequence or mid-charge SHALL discard it; no jump_release on reset deassertion.
REQ-030 First code_valid SHALL be processed no earlier than the first clk edge after rst_n deasserts.

Verification
REQ-031 Bytes 29, then after 3*CHARGE_DIV cycles F0,29 -> jump_press one cycle after 29; jump_release and jump_power=3; jump_charge=0.
REQ-032 E0,6B then 1C then E0,F0,6B -> key_left stays 1 until 1C break; after F0,1C, key_left=0.
REQ-033 Space held for 100*CHARGE_DIV cycles -> jump_charge saturates at 63; release gives jump_power=63.
REQ-034 E0 then no bytes for TIMEOUT_CYC cycles, then 74 -> key_right stays 0 (non-extended 74 ignored).
REQ-035 29 repeated 5 times -> one jump_press only; charge not reset between repeats.
REQ-036 rst_n low while space held with jump_charge=5 -> all outputs 0 immediately; no jump_release after release.
